ssc_uart_rx: RTL and testbench
==============================

SSC_UART_RX -- requirements
Module: ssc_uart_rx

Interface
REQ-001 The module SHALL have the parameter CLOCK_SPEED_HZ, default 54_000_000, giving the clk_logic frequency; it SHALL be used for documentation and assertions only.
REQ-002 The module SHALL have the parameter SYNC_STAGES, default 2, giving the number of input synchronizer flops (minimum 2).
REQ-003 The module SHALL have port clk_logic, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 The module SHALL have port device_reset_n, input, 1 bit: reset that is asynchronous and active-low.
REQ-005 The module SHALL have port enable_i, input, 1 bit: receiver enable.
REQ-006 The module SHALL have port baud_div_i, input, 16 bits: clk_logic cycles per 16x oversample tick; 0 SHALL be treated as 1.
REQ-007 The module SHALL have port word_len_i, input, 2 bits: data bits = 5 + word_len_i.
REQ-008 The module SHALL have ports parity_en_i and parity_odd_i, input, 1 bit each: parity enable and odd(1)/even(0) select.
REQ-009 The module SHALL have port uart_rx_i, input, 1 bit: asynchronous serial line, idle high.
REQ-010 The module SHALL have port rd_i, input, 1 bit: one-cycle strobe meaning "holding register read".
REQ-011 The module SHALL have port rx_data_o, output, 8 bits: received character, right-aligned, unused upper bits 0.
REQ-012 The module SHALL have port rx_full_o, output, 1 bit: holding register valid.
REQ-013 The module SHALL have ports parity_err_o, framing_err_o, overrun_o and break_o, output, 1 bit each: status flags.

Function
REQ-014 uart_rx_i SHALL pass through SYNC_STAGES flops before use; all line references below mean the synchronized value.
REQ-015 The prescaler SHALL count 0..max(baud_div_i,1)-1 freely and SHALL assert tick for one cycle at terminal count.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and BREAK_WAIT.
REQ-017 IDLE: on a tick with the line at 0, the FSM SHALL go to START and clear the 4-bit oversample counter os_cnt.
REQ-018 START: when os_cnt reaches 7, the line SHALL be sampled; a 1 SHALL be a false start and return the FSM to IDLE with no flag; a 0 SHALL clear os_cnt and move the FSM to DATA.
REQ-019 In DATA, PARITY and STOP, a sample SHALL be taken on the tick where os_cnt reaches 15, which is mid-bit.
REQ-020 DATA: bits SHALL be received LSB first, 5+word_len_i of them; the FSM SHALL then go to PARITY if parity_en_i, else to STOP.
REQ-021 PARITY: the mismatch SHALL be computed over the data bits plus the parity bit; even requires an even count of ones, odd requires an odd count.
REQ-022 STOP: only the first stop bit SHALL be checked; a sampled 0 SHALL be a framing error.
REQ-023 On the STOP sample, the FSM SHALL go to IDLE, or to BREAK_WAIT on framing error; BREAK_WAIT SHALL wait for the line to be 1, then go to IDLE.
REQ-024 Completion (STOP sample) with rx_full_o=0, or with rd_i in the same cycle, SHALL load rx_data_o, set rx_full_o=1 and load parity_err_o and framing_err_o for this character, with latency 1 cycle after the sample.
REQ-025 Completion with rx_full_o=1 and no rd_i SHALL set overrun_o=1 and SHALL leave rx_data_o and the error flags unchanged.
REQ-026 rd_i without completion SHALL clear rx_full_o and overrun_o next cycle; rd_i while rx_full_o=0 SHALL have no effect.
REQ-027 break_o SHALL be set on a framing error whose data and parity bits are all 0, and SHALL clear when BREAK_WAIT exits.
REQ-028 When enable_i=0, the FSM SHALL be held in IDLE and os_cnt cleared; the holding register and flags SHALL be retained and rd_i SHALL still function.
REQ-029 Changes to word_len_i or parity inputs mid-character SHALL take effect at the next START; they SHALL be latched on the IDLE->START transition.

Reset
REQ-030 Reset SHALL be asynchronous and active-low on device_reset_n; it SHALL affect every flop.
REQ-031 During reset, the FSM SHALL be in IDLE, the synchronizer flops at 1, and the prescaler, os_cnt and bit counter at 0.
REQ-032 During reset, rx_data_o SHALL be 8'h00 and rx_full_o, parity_err_o, framing_err_o, overrun_o and break_o SHALL be 0.
REQ-033 Reset asserted mid-character SHALL abandon the character with no flags; after release, the receiver SHALL wait for a new falling line.

Structure
REQ-034 The state enum and the word-length/parity encodings SHALL live in a shared package ssc_uart_pkg, reused by the SSC transmitter and registers.
REQ-035 The prescaler SHALL be the sub-module ssc_baud_tick (ports clk_logic, device_reset_n, div_i, tick_o), shared with the transmitter.

Verification
REQ-036 The bench SHALL drive baud_div_i=4, 8N1, byte 8'hA5 -> rx_data_o=8'hA5 and rx_full_o=1 with no errors, one cycle after the STOP mid-sample.
REQ-037 The bench SHALL drive a 7-bit even-parity 7'h41 with a wrong parity bit -> rx_data_o=8'h41 and parity_err_o=1.
REQ-038 The bench SHALL send two bytes, 8'h11 then 8'h22, without rd_i -> rx_data_o=8'h11 and overrun_o=1; a subsequent rd_i -> rx_full_o=0 and overrun_o=0.
REQ-039 The bench SHALL apply a low glitch of 5 ticks on an idle line -> the FSM returns to IDLE and rx_full_o stays 0.
REQ-040 The bench SHALL hold the line low for 20 bit times -> framing_err_o=1, break_o=1 and rx_data_o=8'h00; line high -> break_o=0, then the next byte 8'h5A is received correctly.
REQ-041 The bench SHALL assert rd_i in the same cycle as completion of 8'h33 while full with 8'h22 -> rx_data_o=8'h33, rx_full_o=1 and overrun_o=0; it SHALL also assert reset mid-byte -> all outputs read 0.

Source files
------------

// File: rtl/ssc_uart_pkg.sv
// Shared definitions for the SSC UART receiver, transmitter and register block:
// FSM state, word-length and parity encodings, oversample constants.
package ssc_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } uart_state_e;

  typedef enum logic [1:0] {
    WLEN_5 = 2'd0,
    WLEN_6 = 2'd1,
    WLEN_7 = 2'd2,
    WLEN_8 = 2'd3
  } word_len_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_sel_e;

  localparam logic [3:0] OS_START_SAMPLE = 4'd7;
  localparam logic [3:0] OS_BIT_SAMPLE   = 4'd15;

  // Index of the last data bit for a given word-length code (5..8 bits).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] word_len);
    return 3'd4 + {1'b0, word_len};
  endfunction

  // 1 when data plus parity bit do not have the parity demanded by odd_sel.
  function automatic logic parity_mismatch(input logic [7:0] data,
                                           input logic       par_bit,
                                           input logic       odd_sel);
    return (^{data, par_bit}) ^ odd_sel;
  endfunction

endpackage

// File: rtl/ssc_baud_tick.sv
// Free-running prescaler: one-cycle tick every max(div_i,1) clk_logic cycles.
module ssc_baud_tick (
  input  logic        clk_logic,
  input  logic        device_reset_n,
  input  logic [15:0] div_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] term_s;
  logic        tick_q, tick_d;

  // Terminal-count compare; >= keeps the counter bounded if div_i shrinks.
  always_comb begin
    term_s = 16'd0;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (div_i > 16'd1) begin
      term_s = div_i - 16'd1;
    end else begin
      term_s = 16'd0;
    end
    if (cnt_q >= term_s) begin
      cnt_d  = 16'd0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + 16'd1;
      tick_d = 1'b0;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      cnt_q  <= 16'd0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/ssc_uart_rx_chk.sv
// Invariant checks for ssc_uart_rx; carries no logic of its own.
module ssc_uart_rx_chk #(
  parameter int CLOCK_SPEED_HZ = 54_000_000,
  parameter int SYNC_STAGES    = 2
) (
  input logic clk_logic,
  input logic device_reset_n,
  input logic rx_full_i,
  input logic overrun_i
);

  a_params: assert property (@(posedge clk_logic)
    (SYNC_STAGES >= 2) && (CLOCK_SPEED_HZ > 0));

  a_overrun_needs_full: assert property (@(posedge clk_logic) disable iff (!device_reset_n)
    overrun_i |-> rx_full_i);

endmodule

// File: rtl/ssc_uart_rx.sv
// 16x-oversampled UART receiver with a single holding register and
// parity / framing / overrun / break status.
module ssc_uart_rx
  import ssc_uart_pkg::*;
#(
  parameter int CLOCK_SPEED_HZ = 54_000_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk_logic,
  input  logic        device_reset_n,
  input  logic        enable_i,
  input  logic [15:0] baud_div_i,
  input  logic [1:0]  word_len_i,
  input  logic        parity_en_i,
  input  logic        parity_odd_i,
  input  logic        uart_rx_i,
  input  logic        rd_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_full_o,
  output logic        parity_err_o,
  output logic        framing_err_o,
  output logic        overrun_o,
  output logic        break_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line_s;
  logic                   tick_s;

  uart_state_e state_q, state_d;
  logic [3:0]  os_cnt_q, os_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  word_len_e   wlen_q, wlen_d;
  logic        par_en_q, par_en_d;
  parity_sel_e par_sel_q, par_sel_d;
  logic        par_bit_q, par_bit_d;
  logic        perr_pend_q, perr_pend_d;
  logic        done_s, ferr_s, brk_set_s;

  logic [7:0]  data_q, data_d;
  logic        full_q, full_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        brk_q, brk_d;

  ssc_baud_tick u_baud_tick (
    .clk_logic      (clk_logic),
    .device_reset_n (device_reset_n),
    .div_i          (baud_div_i),
    .tick_o         (tick_s)
  );

  ssc_uart_rx_chk #(
    .CLOCK_SPEED_HZ (CLOCK_SPEED_HZ),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_chk (
    .clk_logic      (clk_logic),
    .device_reset_n (device_reset_n),
    .rx_full_i      (full_q),
    .overrun_i      (ovr_q)
  );

  // Line synchronizer, reset to the idle level.
  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
    end
  end

  assign line_s = sync_q[SYNC_STAGES-1];

  // Receive FSM and datapath next-state.
  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    wlen_d      = wlen_q;
    par_en_d    = par_en_q;
    par_sel_d   = par_sel_q;
    par_bit_d   = par_bit_q;
    perr_pend_d = perr_pend_q;
    done_s      = 1'b0;
    ferr_s      = 1'b0;
    if (!enable_i) begin
      state_d   = ST_IDLE;
      os_cnt_d  = 4'd0;
      bit_cnt_d = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick_s && !line_s) begin
            state_d     = ST_START;
            os_cnt_d    = 4'd0;
            bit_cnt_d   = 3'd0;
            shift_d     = 8'h00;
            par_bit_d   = 1'b0;
            perr_pend_d = 1'b0;
            wlen_d      = word_len_e'(word_len_i);
            par_en_d    = parity_en_i;
            par_sel_d   = parity_sel_e'(parity_odd_i);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (tick_s && (os_cnt_q == OS_START_SAMPLE)) begin
            os_cnt_d = 4'd0;
            state_d  = line_s ? ST_IDLE : ST_DATA;
          end else if (tick_s) begin
            os_cnt_d = os_cnt_q + 4'd1;
          end else begin
            os_cnt_d = os_cnt_q;
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            os_cnt_d = os_cnt_q + 4'd1;
            if (os_cnt_q == OS_BIT_SAMPLE) begin
              shift_d[bit_cnt_q] = line_s;
              if (bit_cnt_q == last_bit_idx(wlen_q)) begin
                bit_cnt_d = 3'd0;
                state_d   = par_en_q ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q;
            end
          end else begin
            os_cnt_d = os_cnt_q;
          end
        end
        ST_PARITY: begin
          if (tick_s) begin
            os_cnt_d = os_cnt_q + 4'd1;
            if (os_cnt_q == OS_BIT_SAMPLE) begin
              par_bit_d   = line_s;
              perr_pend_d = parity_mismatch(shift_q, line_s, par_sel_q == PAR_ODD);
              state_d     = ST_STOP;
            end else begin
              state_d = ST_PARITY;
            end
          end else begin
            os_cnt_d = os_cnt_q;
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            os_cnt_d = os_cnt_q + 4'd1;
            if (os_cnt_q == OS_BIT_SAMPLE) begin
              done_s  = 1'b1;
              ferr_s  = !line_s;
              state_d = line_s ? ST_IDLE : ST_BREAK_WAIT;
            end else begin
              state_d = ST_STOP;
            end
          end else begin
            os_cnt_d = os_cnt_q;
          end
        end
        ST_BREAK_WAIT: begin
          if (line_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BREAK_WAIT;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          os_cnt_d = 4'd0;
        end
      endcase
    end
  end

  assign brk_set_s = done_s && ferr_s && (shift_q == 8'h00) && !par_bit_q;

  // Holding register and status flags; a same-cycle read frees the slot.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;
    brk_d  = brk_q;
    if (done_s && (!full_q || rd_i)) begin
      data_d = shift_q;
      full_d = 1'b1;
      perr_d = perr_pend_q;
      ferr_d = ferr_s;
      ovr_d  = 1'b0;
    end else if (done_s) begin
      ovr_d = 1'b1;
    end else if (rd_i && full_q) begin
      full_d = 1'b0;
      ovr_d  = 1'b0;
    end else begin
      full_d = full_q;
    end
    if (brk_set_s) begin
      brk_d = 1'b1;
    end else if ((state_q == ST_BREAK_WAIT) && (state_d != ST_BREAK_WAIT)) begin
      brk_d = 1'b0;
    end else begin
      brk_d = brk_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      state_q     <= ST_IDLE;
      os_cnt_q    <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      wlen_q      <= WLEN_5;
      par_en_q    <= 1'b0;
      par_sel_q   <= PAR_EVEN;
      par_bit_q   <= 1'b0;
      perr_pend_q <= 1'b0;
      data_q      <= 8'h00;
      full_q      <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wlen_q      <= wlen_d;
      par_en_q    <= par_en_d;
      par_sel_q   <= par_sel_d;
      par_bit_q   <= par_bit_d;
      perr_pend_q <= perr_pend_d;
      data_q      <= data_d;
      full_q      <= full_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      brk_q       <= brk_d;
    end
  end

  assign rx_data_o     = data_q;
  assign rx_full_o     = full_q;
  assign parity_err_o  = perr_q;
  assign framing_err_o = ferr_q;
  assign overrun_o     = ovr_q;
  assign break_o       = brk_q;

endmodule

// File: tb/tb_ssc_uart_rx.sv
// Directed bench for ssc_uart_rx at baud_div=4 (64 clk_logic cycles per bit).
module tb_ssc_uart_rx;

  localparam int BIT_CYC = 64;

  logic        clk_logic = 1'b0;
  logic        device_reset_n;
  logic        enable_i;
  logic [15:0] baud_div_i;
  logic [1:0]  word_len_i;
  logic        parity_en_i;
  logic        parity_odd_i;
  logic        uart_rx_i;
  logic        rd_i;
  logic [7:0]  rx_data_o;
  logic        rx_full_o;
  logic        parity_err_o;
  logic        framing_err_o;
  logic        overrun_o;
  logic        break_o;

  int errors = 0;
  int checks = 0;

  ssc_uart_rx dut (
    .clk_logic      (clk_logic),
    .device_reset_n (device_reset_n),
    .enable_i       (enable_i),
    .baud_div_i     (baud_div_i),
    .word_len_i     (word_len_i),
    .parity_en_i    (parity_en_i),
    .parity_odd_i   (parity_odd_i),
    .uart_rx_i      (uart_rx_i),
    .rd_i           (rd_i),
    .rx_data_o      (rx_data_o),
    .rx_full_o      (rx_full_o),
    .parity_err_o   (parity_err_o),
    .framing_err_o  (framing_err_o),
    .overrun_o      (overrun_o),
    .break_o        (break_o)
  );

  always #5 clk_logic = ~clk_logic;

  // Hold the line at v for one bit; pulse rd_i in iteration rd_at; report the
  // first iteration whose end shows rx_full_o high.
  task automatic drive_bit_ex(input logic v, input int rd_at, output int rise_at);
    rise_at   = -1;
    uart_rx_i = v;
    for (int k = 0; k < BIT_CYC; k++) begin
      rd_i = (k == rd_at);
      @(negedge clk_logic);
      if (rise_at < 0 && rx_full_o) rise_at = k;
    end
    rd_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input logic pen,
                            input logic pbit, input int rd_at, output int rise_at);
    int dummy;
    drive_bit_ex(1'b0, -1, dummy);
    for (int i = 0; i < nbits; i++) drive_bit_ex(data[i], -1, dummy);
    if (pen) drive_bit_ex(pbit, -1, dummy);
    drive_bit_ex(1'b1, rd_at, rise_at);
  endtask

  task automatic rd_pulse();
    rd_i = 1'b1;
    @(negedge clk_logic);
    rd_i = 1'b0;
  endtask

  task automatic test_reset();
    device_reset_n = 1'b0;
    repeat (3) @(negedge clk_logic);
    checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", rx_data_o); end
    checks++; if (rx_full_o !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", rx_full_o); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b expected 0", parity_err_o); end
    checks++; if (framing_err_o !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b expected 0", framing_err_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b expected 0", overrun_o); end
    checks++; if (break_o !== 1'b0) begin errors++; $display("FAIL rst_brk: got %b expected 0", break_o); end
    device_reset_n = 1'b1;
    repeat (BIT_CYC) @(negedge clk_logic);
  endtask

  task automatic test_basic();
    int rise;
    send_frame(8'hA5, 8, 1'b0, 1'b0, -1, rise);
    checks++; if (rise < 33 || rise > 38) begin errors++; $display("FAIL basic_latency: full rose at %0d expected 33..38 into stop bit", rise); end
    checks++; if (rx_data_o !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", rx_data_o); end
    checks++; if (rx_full_o !== 1'b1) begin errors++; $display("FAIL basic_full: got %b expected 1", rx_full_o); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b expected 0", parity_err_o); end
    checks++; if (framing_err_o !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b expected 0", framing_err_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL basic_ovr: got %b expected 0", overrun_o); end
    rd_pulse();
    checks++; if (rx_full_o !== 1'b0) begin errors++; $display("FAIL basic_rd_full: got %b expected 0", rx_full_o); end
  endtask

  task automatic test_parity();
    int rise;
    word_len_i = 2'd2; parity_en_i = 1'b1; parity_odd_i = 1'b0;
    send_frame(8'h41, 7, 1'b1, 1'b1, -1, rise);
    checks++; if (rx_data_o !== 8'h41) begin errors++; $display("FAIL par_even_data: got %h expected 41", rx_data_o); end
    checks++; if (parity_err_o !== 1'b1) begin errors++; $display("FAIL par_even_err: got %b expected 1", parity_err_o); end
    checks++; if (framing_err_o !== 1'b0) begin errors++; $display("FAIL par_even_ferr: got %b expected 0", framing_err_o); end
    rd_pulse();
    parity_odd_i = 1'b1;
    send_frame(8'h41, 7, 1'b1, 1'b1, -1, rise);
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL par_odd_err: got %b expected 0", parity_err_o); end
    rd_pulse();
    word_len_i = 2'd0; parity_en_i = 1'b0; parity_odd_i = 1'b0;
    send_frame(8'h15, 5, 1'b0, 1'b0, -1, rise);
    checks++; if (rx_data_o !== 8'h15) begin errors++; $display("FAIL wlen5_data: got %h expected 15", rx_data_o); end
    rd_pulse();
    word_len_i = 2'd3;
  endtask

  task automatic test_overrun();
    int rise;
    send_frame(8'h11, 8, 1'b0, 1'b0, -1, rise);
    send_frame(8'h22, 8, 1'b0, 1'b0, -1, rise);
    checks++; if (rx_data_o !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h expected 11", rx_data_o); end
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun_o); end
    checks++; if (rx_full_o !== 1'b1) begin errors++; $display("FAIL ovr_full: got %b expected 1", rx_full_o); end
    rd_pulse();
    checks++; if (rx_full_o !== 1'b0) begin errors++; $display("FAIL ovr_rd_full: got %b expected 0", rx_full_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_rd_flag: got %b expected 0", overrun_o); end
  endtask

  task automatic test_back_to_back();
    int k0;
    int rise;
    send_frame(8'h22, 8, 1'b0, 1'b0, -1, k0);
    checks++; if (k0 < 33 || k0 > 38) begin errors++; $display("FAIL b2b_latency: full rose at %0d expected 33..38", k0); end
    checks++; if (rx_data_o !== 8'h22) begin errors++; $display("FAIL b2b_first: got %h expected 22", rx_data_o); end
    send_frame(8'h33, 8, 1'b0, 1'b0, k0, rise);
    checks++; if (rx_data_o !== 8'h33) begin errors++; $display("FAIL b2b_data: got %h expected 33", rx_data_o); end
    checks++; if (rx_full_o !== 1'b1) begin errors++; $display("FAIL b2b_full: got %b expected 1", rx_full_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL b2b_ovr: got %b expected 0", overrun_o); end
    rd_pulse();
  endtask

  task automatic test_glitch();
    int rise;
    uart_rx_i = 1'b0;
    repeat (20) @(negedge clk_logic);
    uart_rx_i = 1'b1;
    repeat (3 * BIT_CYC) @(negedge clk_logic);
    checks++; if (rx_full_o !== 1'b0) begin errors++; $display("FAIL glitch_full: got %b expected 0", rx_full_o); end
    checks++; if (framing_err_o !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %b expected 0", framing_err_o); end
    send_frame(8'h96, 8, 1'b0, 1'b0, -1, rise);
    checks++; if (rx_data_o !== 8'h96) begin errors++; $display("FAIL glitch_next: got %h expected 96", rx_data_o); end
    rd_pulse();
  endtask

  task automatic test_break();
    int rise;
    uart_rx_i = 1'b0;
    repeat (20 * BIT_CYC) @(negedge clk_logic);
    checks++; if (framing_err_o !== 1'b1) begin errors++; $display("FAIL brk_ferr: got %b expected 1", framing_err_o); end
    checks++; if (break_o !== 1'b1) begin errors++; $display("FAIL brk_flag: got %b expected 1", break_o); end
    checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL brk_data: got %h expected 00", rx_data_o); end
    checks++; if (rx_full_o !== 1'b1) begin errors++; $display("FAIL brk_full: got %b expected 1", rx_full_o); end
    uart_rx_i = 1'b1;
    repeat (8) @(negedge clk_logic);
    checks++; if (break_o !== 1'b0) begin errors++; $display("FAIL brk_clear: got %b expected 0", break_o); end
    rd_pulse();
    repeat (BIT_CYC) @(negedge clk_logic);
    send_frame(8'h5A, 8, 1'b0, 1'b0, -1, rise);
    checks++; if (rx_data_o !== 8'h5A) begin errors++; $display("FAIL brk_next_data: got %h expected 5a", rx_data_o); end
    checks++; if (framing_err_o !== 1'b0) begin errors++; $display("FAIL brk_next_ferr: got %b expected 0", framing_err_o); end
  endtask

  task automatic test_reset_mid();
    int dummy;
    int rise;
    drive_bit_ex(1'b0, -1, dummy);
    for (int i = 0; i < 3; i++) drive_bit_ex(1'b1, -1, dummy);
    device_reset_n = 1'b0;
    #1;
    checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h expected 00", rx_data_o); end
    checks++; if (rx_full_o !== 1'b0) begin errors++; $display("FAIL rmid_full: got %b expected 0", rx_full_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL rmid_ovr: got %b expected 0", overrun_o); end
    checks++; if (parity_err_o !== 1'b0 || framing_err_o !== 1'b0 || break_o !== 1'b0) begin
      errors++; $display("FAIL rmid_flags: got p=%b f=%b b=%b expected 0", parity_err_o, framing_err_o, break_o);
    end
    uart_rx_i = 1'b1;
    repeat (5) @(negedge clk_logic);
    device_reset_n = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk_logic);
    checks++; if (rx_full_o !== 1'b0) begin errors++; $display("FAIL rmid_after_full: got %b expected 0", rx_full_o); end
    send_frame(8'h0F, 8, 1'b0, 1'b0, -1, rise);
    checks++; if (rx_data_o !== 8'h0F) begin errors++; $display("FAIL rmid_next: got %h expected 0f", rx_data_o); end
  endtask

  initial begin
    device_reset_n = 1'b0;
    enable_i       = 1'b1;
    baud_div_i     = 16'd4;
    word_len_i     = 2'd3;
    parity_en_i    = 1'b0;
    parity_odd_i   = 1'b0;
    uart_rx_i      = 1'b1;
    rd_i           = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_overrun();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
